// File: rtl/cdr_dlf_pkg.sv
// ---------------------------------------------------------------------------
// cdr_dlf_pkg
//   Shared types and helpers for the CDR digital loop filter.
//   - dlf_state_t : loop gain set in use (ACQ = wide-band acquisition,
//                   TRACK = narrow-band tracking).
//   - CALC_W      : width used for all PI arithmetic. It is wide enough that
//                   no intermediate sum can wrap before clamping. Synthesis
//                   trims the upper bits that can never toggle.
//   - acc_width() : vote accumulator width for a given window length.
//   - sat_fw()    : clamp a CALC_W-wide signed value to a signed width.
//   - vote_of()   : map one cycle of phase-detector votes to -1/0/+1.
// ---------------------------------------------------------------------------
package cdr_dlf_pkg;

   typedef enum logic {
      ACQ   = 1'b0,
      TRACK = 1'b1
   } dlf_state_t;

   localparam int CALC_W    = 64;
   localparam int DEC_DEF   = 16;
   localparam int ACC_W_DEF = $clog2(DEC_DEF) + 2;

   // One bit of headroom for |v| = DEC plus the sign bit.
   function automatic int acc_width(input int dec);
      return $clog2(dec) + 2;
   endfunction

   function automatic logic signed [CALC_W-1:0] sat_fw(
      input logic signed [CALC_W-1:0] value,
      input int                       width
   );
      logic signed [CALC_W-1:0] hi;
      logic signed [CALC_W-1:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi) begin
         return hi;
      end
      if (value < lo) begin
         return lo;
      end
      return value;
   endfunction

   // up = late, dn = early; both or neither cancel.
   function automatic logic signed [1:0] vote_of(
      input logic up,
      input logic dn
   );
      if (up && !dn) begin
         return 2'sd1;
      end
      if (dn && !up) begin
         return -2'sd1;
      end
      return 2'sd0;
   endfunction

endpackage

// File: rtl/cdr_dlf_lockdet.sv
// ---------------------------------------------------------------------------
// cdr_dlf_lockdet
//   Lock detector for the CDR loop filter. Once per decimation window it
//   classifies the window sum as quiet (|v| <= LOCK_THR) or noisy and counts
//   consecutive windows that argue for leaving the current gain set. After
//   LOCK_CNT such windows in a row the state flips and the run counter clears.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   ACQ   | acquisition gains; counting consecutive quiet windows
//   TRACK | tracking gains (lock high); counting consecutive noisy windows
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (state = ACQ, rc = 0)
//   win_end  in   high on the last cycle of a decimation window
//   hold     in   freeze state and run counter (loop frozen)
//   v        in   signed window vote sum, valid while win_end is high
//   state    out  current gain set
// ---------------------------------------------------------------------------
module cdr_dlf_lockdet
   import cdr_dlf_pkg::*;
#(
   parameter int ACC_W    = ACC_W_DEF,
   parameter int LOCK_THR = 2,
   parameter int LOCK_CNT = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    win_end,
   input  logic                    hold,
   input  logic signed [ACC_W-1:0] v,
   output dlf_state_t              state
);

   dlf_state_t state_q;
   dlf_state_t state_d;
   logic [7:0] rc_q;
   logic [7:0] rc_d;

   logic [ACC_W-1:0] abs_v;
   logic [31:0]      abs_v32;
   logic             quiet;
   logic [7:0]       rc_inc;
   logic             run_done;

   // |v| never reaches -2^(ACC_W-1), so the negation cannot overflow.
   assign abs_v    = v[ACC_W-1] ? ACC_W'(-v) : ACC_W'(v);
   assign abs_v32  = 32'(abs_v);
   assign quiet    = (abs_v32 <= 32'(LOCK_THR));
   assign rc_inc   = rc_q + 8'd1;
   assign run_done = (rc_inc == 8'(LOCK_CNT));

   always_comb begin
      state_d = state_q;
      rc_d    = rc_q;
      if (win_end && !hold) begin
         unique case (state_q)
            ACQ: begin
               if (quiet) begin
                  if (run_done) begin
                     state_d = TRACK;
                     rc_d    = 8'd0;
                  end else begin
                     rc_d = rc_inc;
                  end
               end else begin
                  rc_d = 8'd0;
               end
            end
            TRACK: begin
               if (!quiet) begin
                  if (run_done) begin
                     state_d = ACQ;
                     rc_d    = 8'd0;
                  end else begin
                     rc_d = rc_inc;
                  end
               end else begin
                  rc_d = 8'd0;
               end
            end
            default: begin
               state_d = ACQ;
               rc_d    = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACQ;
         rc_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/cdr_dlf.sv
// ---------------------------------------------------------------------------
// cdr_dlf
//   Digital loop filter for the bang-bang CDR, feeding the frequency control
//   word of the 4-phase I/Q oscillator. Early/late votes are summed over a
//   DEC-cycle window; at the end of each window a proportional-integral
//   update runs and the new FCW is presented one cycle later with a one-cycle
//   fcw_vld strobe. Gains are shifts, selected by the lock detector
//   (ACQ: KP_ACQ/KI_ACQ, TRACK: KP_TRK/KI_TRK).
//
//   Optional build macro: CDR_DLF_FREEZE_EN
//     Adds input 'freeze'. While high, the integrator and lock detector hold
//     and fcw is driven by the proportional path alone around the held
//     integrator. fcw_vld still pulses every window.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   up       in   PD late vote for this cycle
//   dn       in   PD early vote for this cycle
//   freeze   in   (CDR_DLF_FREEZE_EN only) hold integrator and lock state
//   fcw      out  signed FW-bit frequency control word
//   fcw_vld  out  one-cycle strobe when fcw updates
//   lock     out  high while in TRACK
// ---------------------------------------------------------------------------
module cdr_dlf
   import cdr_dlf_pkg::*;
#(
   parameter int DEC      = 16,
   parameter int FW       = 20,
   parameter int FCW_INIT = 0,
   parameter int KP_ACQ   = 6,
   parameter int KI_ACQ   = 2,
   parameter int KP_TRK   = 4,
   parameter int KI_TRK   = 0,
   parameter int LOCK_THR = 2,
   parameter int LOCK_CNT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 up,
   input  logic                 dn,
`ifdef CDR_DLF_FREEZE_EN
   input  logic                 freeze,
`endif
   output logic signed [FW-1:0] fcw,
   output logic                 fcw_vld,
   output logic                 lock
);

   localparam int CNT_W = $clog2(DEC);
   localparam int ACC_W = acc_width(DEC);

   if (DEC < 2 || DEC > 256 || (DEC & (DEC - 1)) != 0) begin : g_bad_dec
      $error("cdr_dlf: DEC must be a power of 2 in 2..256");
   end
   if (LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_bad_lock_cnt
      $error("cdr_dlf: LOCK_CNT must be in 1..255");
   end

   logic freeze_w;
`ifdef CDR_DLF_FREEZE_EN
   assign freeze_w = freeze;
`else
   assign freeze_w = 1'b0;
`endif

   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [FW-1:0]    integ_q;
   logic signed [FW-1:0]    integ_d;
   logic signed [FW-1:0]    fcw_q;
   logic signed [FW-1:0]    fcw_d;
   logic                    fcw_vld_q;
   logic                    fcw_vld_d;

   logic signed [1:0]        vote;
   logic signed [ACC_W-1:0]  v_win;
   logic                     win_end;
   dlf_state_t               state;
   logic [5:0]               kp_sh;
   logic [5:0]               ki_sh;
   logic signed [CALC_W-1:0] v_ext;
   logic signed [CALC_W-1:0] integ_ext;
   logic signed [CALC_W-1:0] integ_sum;
   logic signed [CALC_W-1:0] integ_new;
   logic signed [CALC_W-1:0] fcw_sum;

   // The window-end cycle's own vote is part of the sum.
   assign vote    = vote_of(up, dn);
   assign v_win   = acc_q + ACC_W'(vote);
   assign win_end = (cnt_q == CNT_W'(DEC - 1));

   // Gains follow the state in effect at window end; a state change made by
   // this window therefore only affects the next one.
   assign kp_sh = (state == TRACK) ? 6'(KP_TRK) : 6'(KP_ACQ);
   assign ki_sh = (state == TRACK) ? 6'(KI_TRK) : 6'(KI_ACQ);

   // Sign-extend into the wide domain, then clamp. Clamping the integrator
   // every update keeps it pinned at a rail under same-sign votes while an
   // opposite-sign window moves it off immediately.
   assign v_ext     = CALC_W'(v_win);
   assign integ_ext = CALC_W'(integ_q);
   assign integ_sum = sat_fw(integ_ext + (v_ext <<< ki_sh), FW);
   assign integ_new = freeze_w ? integ_ext : integ_sum;
   assign fcw_sum   = sat_fw(integ_new + (v_ext <<< kp_sh), FW);

   always_comb begin
      cnt_d     = cnt_q + CNT_W'(1);
      acc_d     = v_win;
      integ_d   = integ_q;
      fcw_d     = fcw_q;
      fcw_vld_d = 1'b0;
      if (win_end) begin
         cnt_d     = '0;
         acc_d     = '0;
         integ_d   = FW'(integ_new);
         fcw_d     = FW'(fcw_sum);
         fcw_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         integ_q   <= FW'(FCW_INIT);
         fcw_q     <= FW'(FCW_INIT);
         fcw_vld_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         integ_q   <= integ_d;
         fcw_q     <= fcw_d;
         fcw_vld_q <= fcw_vld_d;
      end
   end

   cdr_dlf_lockdet #(
      .ACC_W    (ACC_W),
      .LOCK_THR (LOCK_THR),
      .LOCK_CNT (LOCK_CNT)
   ) u_lockdet (
      .clk     (clk),
      .rst     (rst),
      .win_end (win_end),
      .hold    (freeze_w),
      .v       (v_win),
      .state   (state)
   );

   assign fcw     = fcw_q;
   assign fcw_vld = fcw_vld_q;
   assign lock    = (state == TRACK);

endmodule

// File: tb/tb_cdr_dlf.sv
// ---------------------------------------------------------------------------
// tb_cdr_dlf
//   Self-checking bench for cdr_dlf (DEC=16, FW=12, FCW_INIT=100, other gains
//   default). A behavioural model computes the expected fcw/lock for every
//   window when the stimulus is driven and queues it; a negedge monitor pops
//   and compares on every fcw_vld strobe and checks that fcw/lock hold
//   between strobes. Directed checks with hand-derived constants cover reset,
//   latency, lock acquisition/loss, threshold boundaries and saturation.
// ---------------------------------------------------------------------------
module tb_cdr_dlf;

   localparam int DEC      = 16;
   localparam int FW       = 12;
   localparam int FCW_INIT = 100;
   localparam int KP_ACQ   = 6;
   localparam int KI_ACQ   = 2;
   localparam int KP_TRK   = 4;
   localparam int KI_TRK   = 0;
   localparam int LOCK_THR = 2;
   localparam int LOCK_CNT = 8;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 up  = 1'b0;
   logic                 dn  = 1'b0;
   logic signed [FW-1:0] fcw;
   logic                 fcw_vld;
   logic                 lock;
`ifdef CDR_DLF_FREEZE_EN
   logic                 freeze = 1'b0;
`endif

   always #5 clk = ~clk;

   cdr_dlf #(
      .DEC      (DEC),
      .FW       (FW),
      .FCW_INIT (FCW_INIT),
      .KP_ACQ   (KP_ACQ),
      .KI_ACQ   (KI_ACQ),
      .KP_TRK   (KP_TRK),
      .KI_TRK   (KI_TRK),
      .LOCK_THR (LOCK_THR),
      .LOCK_CNT (LOCK_CNT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .up      (up),
      .dn      (dn),
`ifdef CDR_DLF_FREEZE_EN
      .freeze  (freeze),
`endif
      .fcw     (fcw),
      .fcw_vld (fcw_vld),
      .lock    (lock)
   );

   typedef struct packed {
      logic signed [FW-1:0] fcw;
      logic                 lock;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int checks   = 0;
   int failures = 0;

   // model state
   longint               m_i;
   bit                   m_trk;
   int                   m_rc;
   int                   m_cnt;
   int                   m_vsum;
   bit                   m_frz;
   logic signed [FW-1:0] last_fcw;
   logic                 last_lock;

   function automatic longint msat(input longint x);
      longint hi;
      longint lo;
      hi = (longint'(1) << (FW - 1)) - 1;
      lo = -(longint'(1) << (FW - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   task automatic model_window(input int v);
      longint kp;
      longint ki;
      longint prop;
      bit     quiet;
      bit     counts;
      exp_t   e;
      kp   = m_trk ? KP_TRK : KP_ACQ;
      ki   = m_trk ? KI_TRK : KI_ACQ;
      prop = longint'(v) * (longint'(1) << kp);
      if (!m_frz) m_i = msat(m_i + longint'(v) * (longint'(1) << ki));
      e.fcw = FW'(msat(m_i + prop));
      if (!m_frz) begin
         quiet  = ((v < 0) ? -v : v) <= LOCK_THR;
         counts = m_trk ? !quiet : quiet;
         if (counts) begin
            m_rc++;
            if (m_rc == LOCK_CNT) begin
               m_trk = !m_trk;
               m_rc  = 0;
            end
         end else begin
            m_rc = 0;
         end
      end
      e.lock = m_trk;
      exp_q.push_back(e);
   endtask

   task automatic step(input bit u, input bit d);
      up = u;
      dn = d;
      m_vsum += (u && !d) ? 1 : ((d && !u) ? -1 : 0);
      m_cnt++;
      if (m_cnt == DEC) begin
         model_window(m_vsum);
         m_vsum = 0;
         m_cnt  = 0;
      end
      @(posedge clk);
      #1;
   endtask

   // nu late cycles, then nd early cycles, then nb both-high cycles, rest idle
   task automatic window(input int nu, input int nd, input int nb);
      for (int i = 0; i < DEC; i++) begin
         if (i < nu)                step(1'b1, 1'b0);
         else if (i < nu + nd)      step(1'b0, 1'b1);
         else if (i < nu + nd + nb) step(1'b1, 1'b1);
         else                       step(1'b0, 1'b0);
      end
   endtask

   task automatic check_val(input string tag, input longint got, input longint want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      up  = 1'b0;
      dn  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      check_val("rst_fcw", longint'(fcw), FCW_INIT);
      check_val("rst_vld", longint'(fcw_vld), 0);
      check_val("rst_lock", longint'(lock), 0);
      m_i       = FCW_INIT;
      m_trk     = 1'b0;
      m_rc      = 0;
      m_cnt     = 0;
      m_vsum    = 0;
      m_frz     = 1'b0;
      last_fcw  = FW'(FCW_INIT);
      last_lock = 1'b0;
      exp_q.delete();
      rst = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (fcw_vld) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               failures++;
               $error("FAIL vld_unexpected got=1 want=0");
            end
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               checks++;
               assert (fcw === mon_e.fcw) else begin
                  failures++;
                  $error("FAIL sb_fcw got=%0d want=%0d", fcw, mon_e.fcw);
               end
               checks++;
               assert (lock === mon_e.lock) else begin
                  failures++;
                  $error("FAIL sb_lock got=%0b want=%0b", lock, mon_e.lock);
               end
               last_fcw  = mon_e.fcw;
               last_lock = mon_e.lock;
            end
         end else begin
            checks++;
            assert (fcw === last_fcw && lock === last_lock) else begin
               failures++;
               $error("FAIL hold got=%0d/%0b want=%0d/%0b", fcw, lock, last_fcw, last_lock);
            end
         end
      end
   end

   initial begin
      int nu;
      int nd;

      do_reset(3);

      // partial window, then reset mid-window: partial votes must be dropped
      repeat (5) step(1'b1, 1'b0);
      do_reset(3);

      // latency: cycles numbered from 1 at the first cycle with rst low;
      // the strobe belongs to cycle DEC+1 only
      for (int i = 1; i <= DEC; i++) begin
         step(1'b1, 1'b0);
         check_val("vld_latency", longint'(fcw_vld), (i == DEC) ? 1 : 0);
      end
      // I = 100 + 16*4 = 164, fcw = 164 + 16*64 = 1188
      check_val("late_fcw", longint'(fcw), 1188);
      check_val("late_lock", longint'(lock), 0);

      // cancelling votes: fcw stays at FCW_INIT, lock on the 8th strobe
      do_reset(2);
      repeat (7) window(0, 0, DEC);
      check_val("cancel_lock7", longint'(lock), 0);
      window(0, 0, DEC);
      check_val("cancel_lock8", longint'(lock), 1);
      check_val("cancel_fcw", longint'(fcw), FCW_INIT);

      // loss of lock: TRACK gains for 8 windows (I += 16), ACQ from the 9th
      repeat (7) window(DEC, 0, 0);
      check_val("loss_lock7", longint'(lock), 1);
      window(DEC, 0, 0);
      check_val("loss_lock8", longint'(lock), 0);
      check_val("loss_fcw8", longint'(fcw), 484);
      window(DEC, 0, 0);
      check_val("loss_fcw9", longint'(fcw), 1316);

      // threshold boundary in ACQ: |v|=2 is quiet, |v|=3 breaks the run
      do_reset(2);
      repeat (7) window(2, 0, 0);
      window(3, 0, 0);
      repeat (7) window(0, 2, 0);
      check_val("thr_acq_lock", longint'(lock), 0);
      window(0, 2, 0);
      check_val("thr_acq_lock8", longint'(lock), 1);
      // threshold boundary in TRACK
      repeat (7) window(3, 0, 0);
      window(2, 0, 0);
      repeat (7) window(0, 3, 0);
      check_val("thr_trk_lock", longint'(lock), 1);
      window(0, 3, 0);
      check_val("thr_trk_lock8", longint'(lock), 0);

      // saturation at the positive rail, then off the rail in one window
      repeat (40) window(DEC, 0, 0);
      check_val("sat_pos", longint'(fcw), 2047);
      window(0, DEC, 0);
      check_val("sat_release", longint'(fcw), 959);
      repeat (80) window(0, DEC, 0);
      check_val("sat_neg", longint'(fcw), -2048);

      // random windows against the model
      repeat (24) begin
         nu = int'($urandom_range(0, DEC));
         nd = int'($urandom_range(0, DEC - nu));
         window(nu, nd, int'($urandom_range(0, DEC - nu - nd)));
      end

`ifdef CDR_DLF_FREEZE_EN
      do_reset(2);
      window(DEC, 0, 0);
      freeze = 1'b1;
      m_frz  = 1'b1;
      repeat (3) window(DEC, 0, 0);
      check_val("frz_fcw", longint'(fcw), 1188);
      repeat (8) window(0, 0, DEC);
      check_val("frz_lock", longint'(lock), 0);
      freeze = 1'b0;
      m_frz  = 1'b0;
      window(DEC, 0, 0);
      check_val("unfrz_fcw", longint'(fcw), 1252);
`endif

      @(posedge clk);
      #1;
      check_val("sb_drained", longint'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
